pll_lock_reset_seq: RTL and testbench

// Consumes the DDR3 rPLL LOCK output and sequences resets for the memory domain. Runs on the 27 MHz

---
 rtl/pll_lock_reset_seq.sv | 128 ++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// Reset sequencer for the DDR3 rPLL domain: pulses PLL reset, qualifies lock, then releases
// the DDR controller and user-logic resets in order, re-sequencing on lock loss.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 270000,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             calib_done,
  output logic             pll_rst,
  output logic             ddr_rst_n,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);
  // state     | meaning
  // PLL_RST   | pll_rst driven high for PLL_RST_CYC cycles
  // WAIT_LOCK | waiting for LOCK_STABLE_CYC consecutive synced-lock cycles, or timeout
  // DDR_REL   | DDR controller out of reset, waiting for calibration done
  // RUN       | all resets released, ready high

  localparam int MAX_AB  = (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC;
  localparam int MAX_CYC = (MAX_AB > PLL_RST_CYC) ? MAX_AB : PLL_RST_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE_CYC + 1);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE_CYC);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_DDR_REL   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state;
  logic [TMR_W-1:0]       timer;
  logic [STB_W-1:0]       stable;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] cal_sync;
  logic                   lock_s;
  logic                   cal_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= '0;
      cal_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
      cal_sync  <= {cal_sync[SYNC_STAGES-2:0], calib_done};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign cal_s  = cal_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLL_RST;
      timer     <= '0;
      stable    <= '0;
      pll_rst   <= 1'b1;
      ddr_rst_n <= 1'b0;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else if ((state == S_DDR_REL || state == S_RUN) && !lock_s) begin
      // lock lost after release: pull both resets and re-qualify lock without a PLL reset
      state     <= S_WAIT_LOCK;
      timer     <= '0;
      stable    <= '0;
      ddr_rst_n <= 1'b0;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      if (loss_cnt != '1) loss_cnt <= loss_cnt + CNT_W'(1);
    end else begin
      case (state)
        S_PLL_RST: begin
          if (timer == RST_LAST) begin
            state   <= S_WAIT_LOCK;
            timer   <= '0;
            stable  <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          // stability is tested first so a coincident timeout does not trigger a retry
          if (stable == STB_DONE) begin
            state     <= S_DDR_REL;
            ddr_rst_n <= 1'b1;
          end else if (timer == TMO_LAST) begin
            state   <= S_PLL_RST;
            timer   <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt != '1) retry_cnt <= retry_cnt + CNT_W'(1);
          end else begin
            timer  <= timer + TMR_W'(1);
            stable <= lock_s ? stable + STB_W'(1) : '0;
          end
        end
        S_DDR_REL: begin
          if (cal_s) begin
            state     <= S_RUN;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_PLL_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed sequences plus random lock/calibration traffic,
// all outputs compared every cycle against a window-based model of the sequencing rules.
module tb_pll_lock_reset_seq;
  localparam int P_SYNC = 2;
  localparam int P_RST  = 4;
  localparam int P_STB  = 8;
  localparam int P_TMO  = 50;
  localparam int P_CW   = 4;
  localparam int P_SAT  = (1 << P_CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pll_lock = 1'b0;
  logic            calib_done = 1'b0;
  logic            pll_rst;
  logic            ddr_rst_n;
  logic            sys_rst_n;
  logic            ready;
  logic [P_CW-1:0] retry_cnt;
  logic [P_CW-1:0] loss_cnt;

  pll_lock_reset_seq #(
    .SYNC_STAGES(P_SYNC), .PLL_RST_CYC(P_RST), .LOCK_STABLE_CYC(P_STB),
    .LOCK_TIMEOUT_CYC(P_TMO), .CNT_W(P_CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .calib_done(calib_done),
    .pll_rst(pll_rst), .ddr_rst_n(ddr_rst_n), .sys_rst_n(sys_rst_n), .ready(ready),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // model: phase 0 PLL reset, 1 waiting for lock, 2 DDR released, 3 running
  int m_t, m_phase, m_entry, m_retry, m_loss;
  bit hist_l[$];
  bit hist_c[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  // value of an input as the sequencer sees it at edge s: driven after edge s-SYNC-1
  function automatic bit seen_l(input int s);
    int i = s - P_SYNC - 1;
    return (i >= 0 && i < hist_l.size()) ? hist_l[i] : 1'b0;
  endfunction

  function automatic bit seen_c(input int s);
    int i = s - P_SYNC - 1;
    return (i >= 0 && i < hist_c.size()) ? hist_c[i] : 1'b0;
  endfunction

  task automatic model_reset();
    m_t = 0; m_phase = 0; m_entry = 0; m_retry = 0; m_loss = 0;
    hist_l.delete(); hist_c.delete();
    hist_l.push_back(pll_lock);
    hist_c.push_back(calib_done);
  endtask

  task automatic model_edge();
    bit ok;
    m_t++;
    case (m_phase)
      0: if (m_t - m_entry == P_RST) begin m_phase = 1; m_entry = m_t; end
      1: begin
        // lock is stable once the last P_STB samples since entry were all high
        ok = (m_t - P_STB >= m_entry + 1);
        for (int s = m_t - P_STB; s < m_t; s++) if (!seen_l(s)) ok = 1'b0;
        if (ok) m_phase = 2;
        else if (m_t - m_entry == P_TMO) begin
          m_phase = 0; m_entry = m_t;
          if (m_retry < P_SAT) m_retry++;
        end
      end
      default: begin
        if (!seen_l(m_t)) begin
          m_phase = 1; m_entry = m_t;
          if (m_loss < P_SAT) m_loss++;
        end else if (m_phase == 2 && seen_c(m_t)) m_phase = 3;
      end
    endcase
  endtask

  task automatic cycle(input bit l, input bit c);
    @(posedge clk);
    model_edge();
    #1;
    pll_lock = l;
    calib_done = c;
    hist_l.push_back(l);
    hist_c.push_back(c);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
  endtask

  task automatic wait_entry();
    int n = 0;
    do begin cycle(1'b0, 1'b0); n++; end
    while (!(m_phase == 1 && m_entry == m_t) && n < 200);
    if (n >= 200) chk("wait_entry_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pll_rst",   int'(pll_rst),   int'(m_phase == 0));
      chk("ddr_rst_n", int'(ddr_rst_n), int'(m_phase >= 2));
      chk("sys_rst_n", int'(sys_rst_n), int'(m_phase == 3));
      chk("ready",     int'(ready),     int'(m_phase == 3));
      chk("retry_cnt", int'(retry_cnt), m_retry);
      chk("loss_cnt",  int'(loss_cnt),  m_loss);
    end
  end

  initial begin
    int n;
    int r0;
    bit lv;
    model_reset();
    repeat (3) @(posedge clk);
    release_reset();

    // PLL reset pulse, timeout retry, saturation
    n = 0;
    while (pll_rst && n < 20) begin cycle(1'b0, 1'b0); n++; end
    chk("pll_rst_pulse_len", n, 4);
    n = 0;
    while (!pll_rst && n < 100) begin cycle(1'b0, 1'b0); n++; end
    chk("timeout_gap", n, 50);
    chk("retry_after_first", int'(retry_cnt), 1);
    repeat (19 * 54 + 10) cycle(1'b0, 1'b0);
    chk("retry_saturated", int'(retry_cnt), 15);

    // lock at cycle 10 after pll_rst falls, then calibration
    wait_entry();
    repeat (9) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    n = 0;
    while (!ddr_rst_n && n < 40) begin cycle(1'b1, 1'b0); n++; end
    chk("lock_to_ddr_latency", n, 11);
    repeat (5) cycle(1'b1, 1'b0);
    chk("sys_held_before_cal", int'(sys_rst_n), 0);
    cycle(1'b1, 1'b1);
    n = 0;
    while (!sys_rst_n && n < 40) begin cycle(1'b1, 1'b1); n++; end
    chk("cal_to_sys_latency", n, 3);
    chk("ready_in_run", int'(ready), 1);

    // one-cycle lock drop in RUN, then full re-sequence
    cycle(1'b0, 1'b1);
    n = 0;
    while (ddr_rst_n && n < 40) begin cycle(1'b1, 1'b1); n++; end
    chk("loss_to_ddr_low", n, 3);
    chk("loss_sys_low", int'(sys_rst_n), 0);
    chk("loss_cnt_one", int'(loss_cnt), 1);
    n = 0;
    while (!ready && n < 60) begin cycle(1'b1, 1'b1); n++; end
    chk("resequence_ready", int'(ready), 1);

    // glitch in WAIT_LOCK restarts the stability count
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    n = 0;
    while (!ddr_rst_n && n < 40) begin cycle(1'b1, 1'b0); n++; end
    chk("glitch_rerise_latency", n, 11);
    n = 0;
    while (!ready && n < 40) begin cycle(1'b1, 1'b1); n++; end

    // asynchronous reset mid-RUN
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_pll_rst",   int'(pll_rst),   1);
    chk("async_ddr_rst_n", int'(ddr_rst_n), 0);
    chk("async_sys_rst_n", int'(sys_rst_n), 0);
    chk("async_ready",     int'(ready),     0);
    chk("async_loss_cnt",  int'(loss_cnt),  0);
    pll_lock = 1'b0;
    calib_done = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    n = 0;
    while (pll_rst && n < 20) begin cycle(1'b0, 1'b0); n++; end
    chk("restart_pulse_len", n, 4);

    // stable count completes on exactly the timeout edge: stable wins
    wait_entry();
    r0 = int'(retry_cnt);
    repeat (38) cycle(1'b0, 1'b0);
    repeat (12) cycle(1'b1, 1'b0);
    chk("coincident_ddr_rel", int'(ddr_rst_n), 1);
    chk("coincident_retry", int'(retry_cnt), r0);
    // one cycle later the timeout wins
    wait_entry();
    repeat (39) cycle(1'b0, 1'b0);
    repeat (11) cycle(1'b1, 1'b0);
    chk("late_lock_pll_rst", int'(pll_rst), 1);
    chk("late_lock_retry", int'(retry_cnt), r0 + 1);

    // random lock bursts and calibration
    lv = 1'b1;
    for (int b = 0; b < 120; b++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
      repeat (n) cycle(lv, $urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 2) != 0) ? ~lv : lv;
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
